// File: rtl/shift_seq.sv
// shift_seq: iterative shift/rotate sequencer.
// Accepts a word and shift amount over valid/ready. It applies the shift in
// steps of at most STEP positions per cycle. The result is held until the
// consumer takes it.
// ROTATE / TO_RIGHT: 1'b1 = enable, 1'b0 = disable.
module shift_seq #(
   parameter int DATA     = 8,
   parameter int SHAMT    = 4,
   parameter int STEP     = 2,
   parameter bit ROTATE   = 1'b0,
   parameter bit TO_RIGHT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATA-1:0]  in_data,
   input  logic [SHAMT-1:0] in_shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATA-1:0]  out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] STEP_W = 32'(STEP);

   state_t           state_r;
   logic [DATA-1:0]  acc_r;
   logic [SHAMT-1:0] rem_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [SHAMT-1:0] step_s;
   logic [DATA-1:0]  next_acc_s;

   // One-position move in the configured direction and mode.
   function automatic logic [DATA-1:0] step1(input logic [DATA-1:0] v);
      logic [DATA-1:0] r;
      if (TO_RIGHT) begin
         r = ROTATE ? {v[0], v[DATA-1:1]} : {1'b0, v[DATA-1:1]};
      end else begin
         r = ROTATE ? {v[DATA-2:0], v[DATA-1]} : {v[DATA-2:0], 1'b0};
      end
      return r;
   endfunction

   // Chain of STEP single-position stages; stage i is active when i < amt.
   function automatic logic [DATA-1:0] shift_by(input logic [DATA-1:0] v,
                                                input logic [SHAMT-1:0] amt);
      logic [DATA-1:0] r;
      logic [31:0]     a32;
      r   = v;
      a32 = 32'(amt);
      for (int i = 0; i < STEP; i++) begin
         if (32'(i) < a32) begin
            r = step1(r);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Step size for this cycle: min(remaining, STEP).
   always_comb begin
      step_s = rem_r;
      if (32'(rem_r) > STEP_W) begin
         step_s = STEP_W[SHAMT-1:0];
      end else begin
         step_s = rem_r;
      end
   end

   // Accumulator value after applying this cycle's step.
   always_comb begin
      next_acc_s = shift_by(acc_r, step_s);
   end

   // Control FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= {DATA{1'b0}};
         rem_r       <= {SHAMT{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  acc_r      <= in_data;
                  rem_r      <= in_shamt;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  if (in_shamt == {SHAMT{1'b0}}) begin
                     state_r     <= DONE;
                     out_valid_r <= 1'b1;
                  end else begin
                     state_r     <= RUN;
                     out_valid_r <= 1'b0;
                  end
               end
            end
            RUN: begin
               acc_r <= next_acc_s;
               rem_r <= rem_r - step_s;
               // Shift mode keeps iterating even once the word is all zero.
               if (rem_r == step_s) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               // No same-cycle acceptance: the next request waits in IDLE.
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               rem_r       <= {SHAMT{1'b0}};
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_data  = acc_r;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: seven instances sharing one request stream.
// Index 0..3 use STEP=2 with the four modes (SL, SR, RL, RR).
// Index 4 is STEP=1 RR, index 5 is STEP=3 SL, index 6 is STEP=8 RL.
module tb_shift_seq;

   localparam int N = 7;

   function automatic int step_of(input int k);
      case (k)
         4:       return 1;
         5:       return 3;
         6:       return 8;
         default: return 2;
      endcase
   endfunction

   function automatic bit rot_of(input int k);
      return (k == 2) || (k == 3) || (k == 4) || (k == 6);
   endfunction

   function automatic bit right_of(input int k);
      return (k == 1) || (k == 3) || (k == 4);
   endfunction

   // Reference result computed directly with whole-word operators.
   function automatic logic [7:0] model(input logic [7:0] d, input int s,
                                        input bit rot, input bit right);
      logic [15:0] t;
      int r;
      if (!rot) begin
         if (s >= 8) return 8'h00;
         return right ? (d >> s) : (d << s);
      end
      r = s % 8;
      t = {d, d};
      if (right) begin
         t = t >> r;
         return t[7:0];
      end
      t = t << r;
      return t[15:8];
   endfunction

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [7:0]   in_data;
   logic [3:0]   in_shamt;
   logic         out_ready;
   logic [N-1:0] in_rdy;
   logic [N-1:0] ov;
   logic [N-1:0] bz;
   logic [7:0]   od [N];

   int nvec;
   int nfail;
   int         last_lat [N];
   int         last_idl [N];
   logic [7:0] last_res [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      shift_seq #(
         .DATA(8), .SHAMT(4), .STEP(step_of(g)),
         .ROTATE(rot_of(g)), .TO_RIGHT(right_of(g))
      ) u_dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid), .in_ready(in_rdy[g]),
         .in_data(in_data), .in_shamt(in_shamt),
         .out_valid(ov[g]), .out_ready(out_ready),
         .out_data(od[g]), .busy(bz[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (in_rdy !== 7'h7F && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      nvec++;
      if (in_rdy !== 7'h7F) begin
         nfail++;
         $display("FAIL idle_wait: in_ready=%b required 1111111", in_rdy);
      end
   endtask

   // Issue one request to all instances and track every instance to completion.
   task automatic run_one(input logic [7:0] d, input logic [3:0] s, input bit stall);
      int   cyc;
      bit   all_done;
      bit   stl [N];
      int   exp_lat;
      logic [7:0] exp_res;
      wait_idle();
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      in_shamt = s + 4'd5;
      for (int k = 0; k < N; k++) begin
         last_lat[k] = -1;
         last_idl[k] = -1;
         last_res[k] = 8'hxx;
         stl[k]      = 1'b0;
      end
      cyc = 0;
      all_done = 1'b0;
      while (!all_done && cyc < 200) begin
         all_done = 1'b1;
         for (int k = 0; k < N; k++) begin
            if (stl[k]) begin
               nvec++;
               if (ov[k] !== 1'b1 || od[k] !== last_res[k]) begin
                  nfail++;
                  $display("FAIL hold dut%0d: valid=%b data=%h required valid=1 data=%h",
                           k, ov[k], od[k], last_res[k]);
               end
            end
            if (ov[k] === 1'b1 && last_lat[k] < 0) begin
               last_lat[k] = cyc;
               last_res[k] = od[k];
            end
            if (last_lat[k] >= 0 && last_idl[k] < 0 && in_rdy[k] === 1'b1) begin
               last_idl[k] = cyc;
            end
            if (last_idl[k] < 0) all_done = 1'b0;
         end
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int k = 0; k < N; k++) begin
            stl[k] = (ov[k] === 1'b1) && !out_ready;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         exp_lat = (int'(s) + step_of(k) - 1) / step_of(k);
         exp_res = model(d, int'(s), rot_of(k), right_of(k));
         nvec++;
         if (last_lat[k] != exp_lat) begin
            nfail++;
            $display("FAIL latency dut%0d d=%h s=%0d: got %0d required %0d",
                     k, d, s, last_lat[k], exp_lat);
         end
         nvec++;
         if (last_res[k] !== exp_res) begin
            nfail++;
            $display("FAIL result dut%0d d=%h s=%0d: got %h required %h",
                     k, d, s, last_res[k], exp_res);
         end
         nvec++;
         if (last_idl[k] < last_lat[k] + 1 || (!stall && last_idl[k] != last_lat[k] + 1)) begin
            nfail++;
            $display("FAIL release dut%0d: idle at %0d, valid at %0d", k, last_idl[k], last_lat[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      in_shamt = 4'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      nvec++;
      if (in_rdy !== 7'h7F || ov !== 7'h00 || bz !== 7'h00) begin
         nfail++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1111111/0000000/0000000",
                  in_rdy, ov, bz);
      end
      for (int k = 0; k < N; k++) begin
         nvec++;
         if (od[k] !== 8'h00) begin
            nfail++;
            $display("FAIL reset_data dut%0d: got %h required 00", k, od[k]);
         end
      end
   endtask

   task automatic test_shift_left();
      run_one(8'h81, 4'd3, 1'b0);
      nvec++;
      if (last_res[0] !== 8'h08 || last_lat[0] != 2 || last_idl[0] != 3) begin
         nfail++;
         $display("FAIL shl_81_3: data=%h lat=%0d idle=%0d required 08 2 3",
                  last_res[0], last_lat[0], last_idl[0]);
      end
   endtask

   task automatic test_rotate();
      run_one(8'h81, 4'd5, 1'b0);
      nvec++;
      if (last_res[3] !== 8'h0C || last_lat[3] != 3) begin
         nfail++;
         $display("FAIL ror_81_5: data=%h lat=%0d required 0c 3", last_res[3], last_lat[3]);
      end
      run_one(8'h81, 4'd15, 1'b0);
      nvec++;
      if (last_res[2] !== 8'hC0 || last_lat[2] != 8) begin
         nfail++;
         $display("FAIL rol_81_15: data=%h lat=%0d required c0 8", last_res[2], last_lat[2]);
      end
   endtask

   task automatic test_boundaries();
      run_one(8'hF0, 4'd0, 1'b0);
      nvec++;
      if (last_res[1] !== 8'hF0 || last_lat[1] != 0) begin
         nfail++;
         $display("FAIL shr_f0_0: data=%h lat=%0d required f0 0", last_res[1], last_lat[1]);
      end
      run_one(8'hFF, 4'd12, 1'b0);
      nvec++;
      if (last_res[1] !== 8'h00 || last_lat[1] != 6) begin
         nfail++;
         $display("FAIL shr_ff_12: data=%h lat=%0d required 00 6", last_res[1], last_lat[1]);
      end
   endtask

   task automatic test_backpressure();
      wait_idle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h81;
      in_shamt  = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (ov[0] !== 1'b1 || od[0] !== 8'h08) begin
         nfail++;
         $display("FAIL bp_rise: valid=%b data=%h required 1 08", ov[0], od[0]);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_shamt = 4'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         nvec++;
         if (ov[0] !== 1'b1 || od[0] !== 8'h08 || in_rdy !== 7'h00) begin
            nfail++;
            $display("FAIL bp_hold: valid=%b data=%h in_ready=%b required 1 08 0000000",
                     ov[0], od[0], in_rdy);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      nvec++;
      if (in_rdy[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
         nfail++;
         $display("FAIL bp_release: in_ready=%b valid=%b busy=%b required 1 0 0",
                  in_rdy[0], ov[0], bz[0]);
      end
      @(posedge clk); #1;
      nvec++;
      if (ov[0] !== 1'b0) begin
         nfail++;
         $display("FAIL bp_no_extra: valid=%b required 0", ov[0]);
      end
   endtask

   task automatic test_midrun_reset();
      bit seen;
      wait_idle();
      in_valid = 1'b1;
      in_data  = 8'hA5;
      in_shamt = 4'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      nvec++;
      if (in_rdy !== 7'h7F || ov !== 7'h00 || bz !== 7'h00 || od[0] !== 8'h00) begin
         nfail++;
         $display("FAIL midrun_reset: in_ready=%b valid=%b busy=%b data0=%h required 1111111 0000000 0000000 00",
                  in_rdy, ov, bz, od[0]);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (ov !== 7'h00) seen = 1'b1;
      end
      nvec++;
      if (seen) begin
         nfail++;
         $display("FAIL midrun_discard: out_valid seen=%b required 0", seen);
      end
      run_one(8'h01, 4'd1, 1'b0);
      nvec++;
      if (last_res[0] !== 8'h02 || last_lat[0] != 1) begin
         nfail++;
         $display("FAIL post_reset: data=%h lat=%0d required 02 1", last_res[0], last_lat[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_one(8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      end
   endtask

   initial begin
      nvec  = 0;
      nfail = 0;
      test_reset();
      test_shift_left();
      test_rotate();
      test_boundaries();
      test_backpressure();
      test_midrun_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
